// File: rtl/leb128_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : leb128_writer                                              |
// | Description : Unsigned LEB128 encoder. Takes one value per in_valid /    |
// |               in_ready handshake and emits it little-endian, 7 payload   |
// |               bits per byte, one byte per out_valid / out_ready beat.    |
// | Option      : LEB128_WRITER_PAD_EN adds min_bytes and pads the encoding  |
// |               up to a minimum length.                                    |
// | Ports       : clk, rst (async, active high)                              |
// |               in_valid/in_ready/in_data[DATA_W]  - value input           |
// |               min_bytes[4]                       - minimum length (opt.) |
// |               out_valid/out_ready/out_byte[8]    - byte stream           |
// |               out_last, out_len[4]               - framing info          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module leb128_writer #(
  parameter int DATA_W    = 56,
  parameter int MAX_BYTES = (DATA_W + 6) / 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef LEB128_WRITER_PAD_EN
  input  logic [3:0]        min_bytes,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic [3:0]        out_len
);

  localparam int SHIFT_W = 7 * MAX_BYTES;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [SHIFT_W-1:0] shift;
  logic [3:0]         remaining;
  logic [3:0]         len;

  logic [SHIFT_W-1:0] data_ext;
  logic [3:0]         n_natural;
  logic [3:0]         n_load;
  logic               accept;
  logic               out_fire;

  // Zero-extend without a replication that would be zero-width at DATA_W=56.
  always_comb begin
    data_ext              = '0;
    data_ext[DATA_W-1:0]  = in_data;
  end

  // Natural length = index of highest non-zero 7-bit group + 1, minimum 1.
  always_comb begin
    n_natural = 4'd1;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (data_ext[7*i +: 7] != 7'd0) n_natural = 4'(i + 1);
    end
  end

`ifdef LEB128_WRITER_PAD_EN
  logic [3:0] min_eff;
  always_comb begin
    min_eff = (min_bytes == 4'd0) ? 4'd1 : min_bytes;
    if (min_eff > 4'(MAX_BYTES)) min_eff = 4'(MAX_BYTES);
    n_load = (n_natural > min_eff) ? n_natural : min_eff;
  end
`else
  always_comb n_load = n_natural;
`endif

  assign out_valid = (state == EMIT);
  // Padding bytes fall out naturally: the shift register is zero above the
  // value, and continuation is driven by the remaining count alone.
  assign out_byte  = {remaining > 4'd1, shift[6:0]};
  assign out_last  = (remaining == 4'd1);
  assign out_len   = len;
  assign out_fire  = out_valid & out_ready;
  // Ready on the final byte's handshake lets the next value follow with no bubble.
  assign in_ready  = (state == IDLE) | (out_fire & out_last);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = EMIT;
      EMIT: if (out_fire && out_last) state_nxt = accept ? EMIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A reload on accept wins over the shift of the final byte in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift     <= '0;
      remaining <= 4'd0;
      len       <= 4'd0;
    end else if (accept) begin
      shift     <= data_ext;
      remaining <= n_load;
      len       <= n_load;
    end else if (out_fire) begin
      shift     <= shift >> 7;
      remaining <= remaining - 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_leb128_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_leb128_writer                                           |
// | Description : Self-checking bench for leb128_writer. A queue model of    |
// |               the expected byte stream is checked every cycle; directed  |
// |               vectors are also pinned against literal byte sequences.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_leb128_writer;

  localparam int DATA_W    = 56;
  localparam int MAX_BYTES = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [3:0]        min_bytes;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic              out_last;
  logic [3:0]        out_len;

  leb128_writer #(.DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef LEB128_WRITER_PAD_EN
    .min_bytes (min_bytes),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic [3:0] len;
  } exp_t;

  exp_t       q[$];
  logic [7:0] got[$];
  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] byte_at_accept;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference encoding from the arithmetic definition of LEB128.
  task automatic model_push(input logic [63:0] v, input logic [3:0] m);
    int n = 1;
    logic [63:0] t = v >> 7;
    int eff;
    while (t != 0) begin n++; t = t >> 7; end
`ifdef LEB128_WRITER_PAD_EN
    eff = (m == 0) ? 1 : int'(m);
    if (eff > MAX_BYTES) eff = MAX_BYTES;
    if (n < eff) n = eff;
`else
    eff = int'(m);
    eff = 0;
`endif
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.b    = 8'((v >> (7 * i)) & 64'h7F) | ((i < n - 1) ? 8'h80 : 8'h00);
      e.last = (i == n - 1);
      e.len  = 4'(n + eff * 0);
      q.push_back(e);
    end
  endtask

  // Every-cycle compare, sampled on the falling edge between driver updates.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("in_ready", 64'(in_ready),
            64'((q.size() == 0) || (out_ready && q.size() == 1)));
      if (out_valid && q.size() > 0) begin
        check("out_byte", 64'(out_byte), 64'(q[0].b));
        check("out_last", 64'(out_last), 64'(q[0].last));
        check("out_len",  64'(out_len),  64'(q[0].len));
        if (out_ready) begin
          got.push_back(out_byte);
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) model_push(64'(in_data), min_bytes);
    end
  end

  task automatic send(input logic [63:0] v, input logic [3:0] m, input bit keep);
    bit ok = 0;
    in_valid  = 1'b1;
    in_data   = DATA_W'(v);
    min_bytes = m;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; byte_at_accept = out_byte; break; end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!out_valid && q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check("idle_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  // Compare captured bytes to a literal, little-endian packed sequence.
  task automatic expect_seq(input string name, input int n, input logic [63:0] bytes,
                            input logic [3:0] len);
    logic [63:0] packed_v = bytes;
    check({name, "_count"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      check({name, "_byte"}, 64'(got[i]), 64'(packed_v[8*i +: 8]));
    check({name, "_len"}, 64'(out_len), 64'(len));
    got.delete();
  endtask

  initial begin
    logic [63:0] dec;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; min_bytes = 4'd0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_byte",  64'(out_byte),  64'h00);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_out_len",   64'(out_len),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    send(0, 0, 0);   wait_idle(); expect_seq("zero", 1, 64'h00, 4'd1);
    send(127, 0, 0); wait_idle(); expect_seq("v127", 1, 64'h7F, 4'd1);
    send(128, 0, 0); wait_idle(); expect_seq("v128", 2, 64'h0180, 4'd2);
    send(624485, 0, 0); wait_idle(); expect_seq("v624485", 3, 64'h268EE5, 4'd3);

    send(64'h00FF_FFFF_FFFF_FFFF, 0, 0); wait_idle();
    dec = 0;
    for (int i = 0; i < got.size(); i++) dec |= 64'(got[i] & 8'h7F) << (7 * i);
    check("max_decode", dec, 64'h00FF_FFFF_FFFF_FFFF);
    expect_seq("max", 8, 64'h7FFF_FFFF_FFFF_FFFF, 4'd8);

    // Backpressure mid-value: five stalled cycles on byte 2.
    send(624485, 0, 0);
    @(posedge clk); #1; out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1; out_ready = 1'b1;
    wait_idle(); expect_seq("bp", 3, 64'h268EE5, 4'd3);

    // Back-to-back values, in_valid held continuously.
    send(300, 0, 1);
    in_data = DATA_W'(1);
    send(1, 0, 0);
    check("b2b_accept_on_02", 64'(byte_at_accept), 64'h02);
    wait_idle(); expect_seq("b2b", 3, 64'h0102AC, 4'd1);

    // Reset while byte 2 is presented.
    send(624485, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_len",   64'(out_len),   64'd0);
    @(posedge clk); #1; rst = 1'b0; got.delete();
    @(posedge clk); #1;
    send(5, 0, 0); wait_idle(); expect_seq("after_rst", 1, 64'h05, 4'd1);

`ifdef LEB128_WRITER_PAD_EN
    send(5, 4, 0);       wait_idle(); expect_seq("pad4", 4, 64'h0080_8085, 4'd4);
    send(624485, 2, 0);  wait_idle(); expect_seq("pad2", 3, 64'h268EE5, 4'd3);
    send(1, 15, 0);      wait_idle(); expect_seq("pad15", 8, 64'h0080_8080_8080_8081, 4'd8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    check("global_timeout", 64'd0, 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
